// File: rtl/sprite_line_eval_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_line_eval_if
// Description : Sprite RAM read port. The evaluator drives the address and
//               receives the entry one clock later.
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_rd_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;

    modport master (output rd_addr, input  rd_data);
    modport slave  (input  rd_addr, output rd_data);
endinterface
`default_nettype wire

// File: rtl/sprite_line_eval.sv
`default_nettype none
// ============================================================================
// Module      : sprite_line_eval
// Description : Per-scanline sprite evaluator. On every line change it scans
//               the whole sprite RAM and collects up to SLOTS sprites that
//               overlap the next line into a shadow buffer; the shadow buffer
//               is published to the tile-draw units at the following change.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_line_eval #(
    parameter int SPRITE_NUM = 64,
    parameter int ADDR_W     = 6,
    parameter int SLOTS      = 8,
    parameter int SPRITE_H   = 16,
    parameter int POS_W      = 10
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic [POS_W-1:0]      vga_pos_y,
    input  wire logic                  game_window,
    sprite_rd_if.master                rd,
    output logic      [SLOTS*32-1:0]   slot_data,
    output logic      [SLOTS-1:0]      slot_valid,
    output logic                       overflow,
    output logic                       eval_late
);

    localparam int                CNT_W     = $clog2(SLOTS + 1);
    localparam int                IDX_W     = $clog2(SLOTS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SPRITE_NUM - 1);
    localparam logic [CNT_W-1:0]  SLOTS_C   = CNT_W'(SLOTS);
    localparam logic [POS_W-1:0]  HEIGHT_C  = POS_W'(SPRITE_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [POS_W-1:0]        prev_y;
    logic [POS_W-1:0]        target;
    logic [ADDR_W-1:0]       addr;
    logic [CNT_W-1:0]        hit_cnt, hit_cnt_n;
    logic [SLOTS-1:0][31:0]  sh_data, sh_data_n;
    logic [SLOTS-1:0]        sh_valid, sh_valid_n;
    logic                    sh_ovf, sh_ovf_n;
    logic                    line_chg;
    logic                    test_en;
    logic                    hit;
    logic [POS_W-1:0]        y_ext;
    logic [POS_W-1:0]        diff;
    logic [IDX_W-1:0]        slot_idx;

    assign rd.rd_addr = addr;
    assign line_chg   = (vga_pos_y != prev_y);

    // The Y byte is zero-extended, so a sprite near Y=255 never wraps onto line 0.
    assign y_ext    = POS_W'(rd.rd_data[31:24]);
    assign diff     = target - y_ext;
    assign hit      = (target >= y_ext) && (diff < HEIGHT_C);
    assign slot_idx = hit_cnt[IDX_W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and test strobe; the entry for address 0 arrives one cycle after it is issued.
    always_comb begin
        state_n = state;
        test_en = 1'b0;
        case (state)
            IDLE: begin
                state_n = IDLE;
            end
            SCAN: begin
                test_en = (addr != '0);
                if (addr == LAST_ADDR) begin
                    state_n = FLUSH;
                end
            end
            FLUSH: begin
                test_en = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (line_chg) begin
            state_n = SCAN;
        end
    end

    // Shadow buffer after this cycle's test; also what a same-cycle line change publishes.
    always_comb begin
        sh_data_n  = sh_data;
        sh_valid_n = sh_valid;
        sh_ovf_n   = sh_ovf;
        hit_cnt_n  = hit_cnt;
        if (test_en && hit) begin
            if (hit_cnt < SLOTS_C) begin
                sh_data_n[slot_idx]  = rd.rd_data;
                sh_valid_n[slot_idx] = 1'b1;
                hit_cnt_n            = hit_cnt + 1'b1;
            end else begin
                sh_ovf_n = 1'b1;
            end
        end
    end

    // Address sequencing, shadow capture and publication of the active slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_y     <= vga_pos_y;
            target     <= '0;
            addr       <= '0;
            hit_cnt    <= '0;
            sh_data    <= '0;
            sh_valid   <= '0;
            sh_ovf     <= 1'b0;
            slot_data  <= '0;
            slot_valid <= '0;
            overflow   <= 1'b0;
            eval_late  <= 1'b0;
        end else begin
            prev_y <= vga_pos_y;
            if (line_chg) begin
                slot_data  <= sh_data_n;
                slot_valid <= game_window ? sh_valid_n : '0;
                overflow   <= game_window & sh_ovf_n;
                sh_data    <= '0;
                sh_valid   <= '0;
                sh_ovf     <= 1'b0;
                hit_cnt    <= '0;
                target     <= vga_pos_y + 1'b1;
                addr       <= '0;
                if (state != IDLE) begin
                    eval_late <= 1'b1;
                end
            end else begin
                sh_data  <= sh_data_n;
                sh_valid <= sh_valid_n;
                sh_ovf   <= sh_ovf_n;
                hit_cnt  <= hit_cnt_n;
                if ((state == SCAN) && (addr != LAST_ADDR)) begin
                    addr <= addr + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_eval.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_line_eval
// Description : Bench for sprite_line_eval: sprite RAM model, line-level
//               reference model, per-cycle compare, directed and random lines.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_line_eval;

    localparam int SPRITE_NUM = 64;
    localparam int ADDR_W     = 6;
    localparam int SLOTS      = 8;
    localparam int SPRITE_H   = 16;
    localparam int POS_W      = 10;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [POS_W-1:0]   vga_pos_y = 10'd5;
    logic               game_window = 1'b1;
    logic [SLOTS*32-1:0] slot_data;
    logic [SLOTS-1:0]   slot_valid;
    logic               overflow;
    logic               eval_late;

    int n_cmp = 0;
    int n_bad = 0;

    sprite_rd_if #(.ADDR_W(ADDR_W)) rd ();

    sprite_line_eval #(
        .SPRITE_NUM(SPRITE_NUM), .ADDR_W(ADDR_W), .SLOTS(SLOTS),
        .SPRITE_H(SPRITE_H), .POS_W(POS_W)
    ) dut (
        .clk(clk), .rst(rst), .vga_pos_y(vga_pos_y), .game_window(game_window),
        .rd(rd), .slot_data(slot_data), .slot_valid(slot_valid),
        .overflow(overflow), .eval_late(eval_late)
    );

    always #5 clk = ~clk;

    // Sprite RAM with one cycle of read latency.
    logic [31:0] mem [SPRITE_NUM];
    always @(posedge clk) rd.rd_data <= mem[rd.rd_addr];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]    scan_mem [SPRITE_NUM];
    logic [255:0]   m_data  = '0;
    logic [7:0]     m_valid = '0;
    logic           m_ovf   = 1'b0;
    logic           m_late  = 1'b0;
    logic [POS_W-1:0] mprev = '0;
    int             cyc = 0;
    int             scan_start = 0;
    int             scan_tgt = 0;
    bit             scan_on = 1'b0;

    // Sprites among indices 0..last covering line tgt, in index order.
    function automatic void eval_scan(input int tgt, input int last,
                                      output logic [255:0] d, output logic [7:0] v,
                                      output logic o);
        int n;
        n = 0; d = '0; v = '0; o = 1'b0;
        for (int i = 0; i <= last; i++) begin
            int y;
            y = int'(scan_mem[i][31:24]);
            if (tgt >= y && tgt - y < SPRITE_H) begin
                if (n < SLOTS) begin
                    d[32*n +: 32] = scan_mem[i];
                    v[n] = 1'b1;
                    n++;
                end else begin
                    o = 1'b1;
                end
            end
        end
    endfunction

    // At each line change: publish what the previous scan managed to test in k cycles.
    always @(posedge clk) begin
        logic [255:0] d;
        logic [7:0]   v;
        logic         o;
        int           k;
        int           last;
        cyc++;
        if (rst) begin
            m_data = '0; m_valid = '0; m_ovf = 1'b0; m_late = 1'b0;
            scan_on = 1'b0;
        end else if (vga_pos_y != mprev) begin
            k = cyc - scan_start;
            d = '0; v = '0; o = 1'b0;
            if (scan_on) begin
                last = (k - 2 > SPRITE_NUM - 1) ? SPRITE_NUM - 1 : k - 2;
                eval_scan(scan_tgt, last, d, v, o);
                if (k <= SPRITE_NUM + 1) m_late = 1'b1;
            end
            m_data  = d;
            m_valid = game_window ? v : 8'h00;
            m_ovf   = game_window & o;
            scan_on    = 1'b1;
            scan_tgt   = (int'(vga_pos_y) + 1) % (1 << POS_W);
            scan_start = cyc;
            scan_mem   = mem;
        end
        mprev = vga_pos_y;
    end

    // Per-cycle compare of the active outputs.
    always @(negedge clk) begin
        if (!rst) begin
            chk("slot_data",  slot_data,  m_data);
            chk("slot_valid", 256'(slot_valid), 256'(m_valid));
            chk("overflow",   256'(overflow),   256'(m_ovf));
            chk("eval_late",  256'(eval_late),  256'(m_late));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] mk(input int y, input int i);
        return {8'(y), 8'(i), 8'(i + 1), 8'(i) ^ 8'h5A};
    endfunction

    task automatic fill(input int y);
        for (int i = 0; i < SPRITE_NUM; i++) mem[i] = mk(y, i);
    endtask

    task automatic set_y(input int y);
        @(posedge clk); #1;
        vga_pos_y = POS_W'(y);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic settle();
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] exp_d;
        int y;
        fill(200);

        // Reset with the line held at 5.
        idle(2);
        @(negedge clk);
        chk("rst_addr",  256'(rd.rd_addr), 256'd0);
        chk("rst_valid", 256'(slot_valid), 256'd0);
        chk("rst_data",  slot_data, 256'd0);
        chk("rst_flags", 256'({overflow, eval_late}), 256'd0);
        @(posedge clk); #1; rst = 1'b0;
        idle(5); @(negedge clk);
        chk("no_scan_addr", 256'(rd.rd_addr), 256'd0);

        // Single hit at entry 3.
        mem[3] = {8'd20, 8'd40, 8'd7, 8'd0};
        set_y(19); idle(70);
        set_y(20); idle(70);
        set_y(21); settle();
        chk("single_valid", 256'(slot_valid), 256'h01);
        chk("single_data",  256'(slot_data[31:0]), 256'(32'h1428_0700));
        chk("model_single", 256'(m_valid), 256'h01);
        idle(70);

        // Height boundary around Y=100.
        fill(200); mem[0] = mk(100, 0);
        set_y(114); idle(70); set_y(300); settle();
        chk("h_115", 256'(slot_valid), 256'h01);
        idle(70);
        set_y(115); idle(70); set_y(301); settle();
        chk("h_116", 256'(slot_valid), 256'h00);
        idle(70);
        set_y(98); idle(70); set_y(302); settle();
        chk("h_99", 256'(slot_valid), 256'h00);
        idle(70);

        // Overflow: ten sprites on one line.
        fill(200);
        for (int i = 0; i < 10; i++) mem[i] = mk(50, i);
        exp_d = '0;
        for (int i = 0; i < 8; i++) exp_d[32*i +: 32] = mk(50, i);
        set_y(54); idle(70); set_y(300); settle();
        chk("ovf_valid", 256'(slot_valid), 256'hFF);
        chk("ovf_flag",  256'(overflow), 256'd1);
        chk("ovf_data",  slot_data, exp_d);
        chk("model_ovf", m_data, exp_d);
        chk("late_before", 256'(eval_late), 256'd0);
        idle(70);

        // Late line change 30 cycles into a scan.
        fill(200);
        mem[25] = mk(60, 25); mem[28] = mk(60, 28);
        mem[29] = mk(60, 29); mem[40] = mk(60, 40);
        set_y(69); idle(29); set_y(300); settle();
        chk("late_flag",  256'(eval_late), 256'd1);
        chk("late_valid", 256'(slot_valid), 256'h03);
        chk("late_data",  256'(slot_data[63:0]), 256'({mk(60, 28), mk(60, 25)}));
        idle(70);
        set_y(69); idle(70); set_y(301); settle();
        chk("full_valid", 256'(slot_valid), 256'h0F);
        chk("full_data",  256'(slot_data[127:96]), 256'(mk(60, 40)));
        idle(70);

        // Outside the game window the line is blanked.
        fill(200);
        for (int i = 1; i < 4; i++) mem[i] = mk(75, i);
        set_y(79); idle(70);
        @(posedge clk); #1; vga_pos_y = 10'd300; game_window = 1'b0;
        settle();
        chk("win_valid", 256'(slot_valid), 256'h00);
        chk("win_ovf",   256'(overflow), 256'd0);
        #1; game_window = 1'b1;
        idle(70);

        // Random lines, timing and sprite tables.
        for (int it = 0; it < 400; it++) begin
            if (it % 25 == 0) begin
                idle(70);
                for (int i = 0; i < SPRITE_NUM; i++)
                    mem[i] = {8'($urandom_range(0, 255)), 24'($urandom)};
            end
            case ($urandom_range(0, 9))
                0:       y = 1023;
                1:       y = int'(vga_pos_y);
                default: y = $urandom_range(0, 280);
            endcase
            @(posedge clk); #1;
            vga_pos_y   = POS_W'(y);
            game_window = ($urandom_range(0, 7) != 0);
            idle($urandom_range(0, 90));
        end

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
